serial_tx: RTL and testbench
============================

# serial_tx

Serial transmitter that frames parallel words into an asynchronous bit stream: start bit, LSB-first data bits, optional even parity bit, stop bit. It is the driving end of the single-wire serial link whose receive side samples the line with a D flip-flop. It sits between a parallel producer, connected over a valid/ready handshake, and the serial output pin.

## Interface
- DATA_W, 8: data bits per frame; must be ≥ 1.
- CLKS_PER_BIT, 4: clock cycles each bit is held on the line; must be ≥ 1.
- PARITY_EN, 0: 1 inserts an even-parity bit between the last data bit and the stop bit.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  word to transmit; sampled only on the accept edge.
- valid_in  input  1  producer has a word on data_in.
- ready_out  output  1  block can accept a word this cycle.
- data_out  output  1  serial line, registered; idles high.
- busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse at frame completion.

## Operation
- Registered FSM states: IDLE, START, DATA, PARITY, STOP.
- Reset forces:
  - state = IDLE, data_out = 1, tx_done = 0;
  - internal shift register, bit counter and baud counter cleared.
- ready_out = (state == IDLE) && !rst. It is 0 while rst is high.
- busy = (state != IDLE).
- Accept: valid_in && ready_out at an edge. On that edge:
  - data_in is latched into the shift register;
  - the parity bit (XOR of data_in) is latched;
  - state goes to START and data_out goes to 0.
- valid_in while busy is ignored. data_in changes after the accept edge do not affect the frame in flight.
- Baud counter counts 0..CLKS_PER_BIT-1 in each non-IDLE state. The state advances on the edge where the counter equals CLKS_PER_BIT-1, and the counter returns to 0.
- State transitions:
  - START → DATA: data_out = shift[0].
  - DATA: bit counter increments each bit and the shift register shifts right. After bit DATA_W-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: data_out = latched parity, so the total count of ones over data plus parity is even. Then go to STOP.
  - STOP: data_out = 1. Then go to IDLE. tx_done = 1 for exactly the first cycle after that edge.
- Frame length: (DATA_W + 2 + PARITY_EN) × CLKS_PER_BIT cycles, measured from the accept edge to the return-to-IDLE edge.
- Reset mid-frame:
  - the frame is aborted on the next edge with rst high;
  - data_out = 1 in the following cycle;
  - no tx_done is produced;
  - after rst drops, the first accept is possible in the first cycle with rst low.
- CLKS_PER_BIT = 1 is legal: every bit lasts exactly one cycle.
- Counter widths are $clog2 of the range, with a minimum width of 1 bit. The counters never wrap outside their range.

## Timing
- Accept edge at cycle N: data_out = 0 is visible from N+1 and holds for CLKS_PER_BIT cycles.
- Data bit k is visible from N+1+(k+1)·CLKS_PER_BIT.
- Stop bit is held CLKS_PER_BIT cycles. The STOP→IDLE edge is at N+F, where F is the frame length.
- At N+F:
  - ready_out = 1 in the following cycle;
  - tx_done = 1 in the following cycle;
  - data_out stays 1.
- Back-to-back: with valid_in held, the next accept happens at edge N+F+1. The minimum start-to-start spacing is F+1 cycles, which gives one idle-high cycle between frames.
- No combinational path from valid_in to data_out. ready_out depends only on state and rst.

## Test plan
- Defaults, send 0xA5:
  - line sequence is 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles;
  - frame is 40 cycles;
  - tx_done pulses once, 1 cycle;
  - busy is high for 40 cycles.
- PARITY_EN=1:
  - 0xA5 gives parity bit 0 and a 44-cycle frame;
  - 0x07 gives parity bit 1.
- Hold valid_in high with 0x3C and then 0xC3:
  - two frames separated by exactly one idle-high cycle;
  - second frame is bit-exact.
- Pulse valid_in with 0xFF at cycle 10 of a 0x00 frame:
  - the pulse is ignored;
  - the 0x00 frame completes unchanged;
  - no second frame is sent.
- Assert rst at cycle 15 of a frame:
  - data_out = 1, busy = 0, no tx_done;
  - ready_out = 0 during rst and 1 after;
  - a new 0x5A frame sent after reset is correct.
- CLKS_PER_BIT=1, DATA_W=4, send 0x9:
  - line sequence is 0,1,0,0,1,1, one cycle per bit;
  - frame is 6 cycles.

Source files
------------

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - asynchronous serial frame transmitter with valid/ready input
//
// Frames each accepted parallel word as: start bit (0), DATA_W data bits
// LSB first, optional even-parity bit, stop bit (1). Every bit is held on
// the line for CLKS_PER_BIT clock cycles. The line idles high.
//
// Parameters:
//   DATA_W        data bits per frame (>= 1)
//   CLKS_PER_BIT  clock cycles per bit on the line (>= 1)
//   PARITY_EN     1 inserts an even-parity bit before the stop bit
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   data_in    word to transmit, sampled only on the accept edge
//   valid_in   producer has a word on data_in
//   ready_out  block can accept a word this cycle (IDLE and not in reset)
//   data_out   registered serial line, idles high
//   busy       a frame is in progress
//   tx_done    one-cycle pulse after the frame returns to IDLE

module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic              data_out,
   output logic              busy,
   output logic              tx_done
);

   // Counter widths never collapse to zero bits when the range is 1.
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]        state;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] shift_next;
   logic [BIT_W-1:0]  bit_cnt;
   logic [BAUD_W-1:0] baud_cnt;
   logic              parity_bit;
   logic              baud_last;
   logic              accept;

   // ready_out only looks at state and rst, so valid_in never reaches
   // data_out combinationally.
   assign ready_out  = (state == S_IDLE) && !rst;
   assign busy       = (state != S_IDLE);
   assign accept     = valid_in && ready_out;
   assign baud_last  = (baud_cnt == BAUD_LAST);

   // Shifting right exposes the next data bit at bit 0; works for DATA_W = 1.
   assign shift_next = shift_reg >> 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         data_out   <= 1'b1;
         tx_done    <= 1'b0;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         baud_cnt   <= '0;
         parity_bit <= 1'b0;
      end else begin
         tx_done <= 1'b0;

         if (state == S_IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (accept) begin
               shift_reg  <= data_in;
               parity_bit <= ^data_in;
               state      <= S_START;
               data_out   <= 1'b0;
            end
         end else if (!baud_last) begin
            baud_cnt <= baud_cnt + 1'b1;
         end else begin
            // Last cycle of the current bit: move to the next bit.
            baud_cnt <= '0;
            case (state)
               S_START: begin
                  state    <= S_DATA;
                  data_out <= shift_reg[0];
                  bit_cnt  <= '0;
               end

               S_DATA: begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        state    <= S_PARITY;
                        data_out <= parity_bit;
                     end else begin
                        state    <= S_STOP;
                        data_out <= 1'b1;
                     end
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     shift_reg <= shift_next;
                     data_out  <= shift_next[0];
                  end
               end

               S_PARITY: begin
                  state    <= S_STOP;
                  data_out <= 1'b1;
               end

               S_STOP: begin
                  state    <= S_IDLE;
                  data_out <= 1'b1;
                  tx_done  <= 1'b1;
               end

               default: begin
                  // Unreachable encodings recover to an idle-high line.
                  state    <= S_IDLE;
                  data_out <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx in three configurations

module tb_serial_tx;

   typedef struct {
      logic [15:0] bits;
      int          nb;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       valid;
   logic [1:0] sel;

   logic ready0, line0, busy0, done0;
   logic ready1, line1, busy1, done1;
   logic ready2, line2, busy2, done2;

   always #5 clk = ~clk;

   serial_tx u_dflt (
      .clk(clk), .rst(rst), .data_in(data), .valid_in(valid),
      .ready_out(ready0), .data_out(line0), .busy(busy0), .tx_done(done0)
   );

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
      .clk(clk), .rst(rst), .data_in(data), .valid_in(valid),
      .ready_out(ready1), .data_out(line1), .busy(busy1), .tx_done(done1)
   );

   serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_small (
      .clk(clk), .rst(rst), .data_in(data[3:0]), .valid_in(valid),
      .ready_out(ready2), .data_out(line2), .busy(busy2), .tx_done(done2)
   );

   logic mon_ready, mon_line, mon_busy, mon_done;
   assign mon_ready = (sel == 2'd0) ? ready0 : (sel == 2'd1) ? ready1 : ready2;
   assign mon_line  = (sel == 2'd0) ? line0  : (sel == 2'd1) ? line1  : line2;
   assign mon_busy  = (sel == 2'd0) ? busy0  : (sel == 2'd1) ? busy1  : busy2;
   assign mon_done  = (sel == 2'd0) ? done0  : (sel == 2'd1) ? done1  : done2;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int cpb(input logic [1:0] s);
      return (s == 2'd2) ? 1 : 4;
   endfunction

   function automatic int dw(input logic [1:0] s);
      return (s == 2'd2) ? 4 : 8;
   endfunction

   function automatic int pe(input logic [1:0] s);
      return (s == 2'd1) ? 1 : 0;
   endfunction

   // Reference frame: bit i of .bits is the i-th line bit in time order.
   function automatic exp_t make_frame(input logic [1:0] s, input logic [7:0] d);
      exp_t e;
      logic p;
      int   w;
      w      = dw(s);
      e.bits = '0;
      p      = 1'b0;
      e.bits[0] = 1'b0;
      for (int i = 0; i < w; i++) begin
         e.bits[1 + i] = d[i];
         p = p ^ d[i];
      end
      if (pe(s) != 0) e.bits[1 + w] = p;
      e.bits[1 + w + pe(s)] = 1'b1;
      e.nb = w + 2 + pe(s);
      return e;
   endfunction

   exp_t exp_q[$];

   // Monitor state
   exp_t        cur;
   bit          in_frame = 0;
   bit          unexp = 0;
   bit          stable;
   bit          busy_ok;
   int          idx;
   logic [15:0] cap;
   logic [15:0] last_bits = '0;
   int          frames_seen = 0;
   int          starts_seen = 0;
   int          done_cnt = 0;
   int          busy_cnt = 0;
   int          idle_run = 0;
   int          last_gap = -1;

   always @(negedge clk) begin
      if (mon_done === 1'b1) done_cnt++;
      if (rst) begin
         in_frame = 0;
         unexp    = 0;
         idle_run = 0;
         exp_q.delete();
      end else begin
         if (mon_busy === 1'b1) busy_cnt++;
         if (!in_frame) begin
            if (mon_line === 1'b0) begin
               starts_seen++;
               last_gap = idle_run;
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 32'd1, 32'd0);
                  unexp   = 1;
                  cur     = make_frame(sel, 8'h00);
               end else begin
                  unexp = 0;
                  cur   = exp_q.pop_front();
               end
               in_frame = 1;
               cap      = '0;
               cap[0]   = mon_line;
               stable   = 1;
               busy_ok  = (mon_busy === 1'b1);
               idx      = 1;
            end else begin
               idle_run++;
            end
         end else if (idx < cur.nb * cpb(sel)) begin
            if ((idx % cpb(sel)) == 0) cap[idx / cpb(sel)] = mon_line;
            else if (mon_line !== cap[idx / cpb(sel)]) stable = 0;
            if (mon_busy !== 1'b1) busy_ok = 0;
            idx++;
         end else begin
            // First cycle after the STOP->IDLE edge.
            if (!unexp) chk("frame_bits", 32'(cap), 32'(cur.bits));
            chk("bit_hold", 32'(stable), 32'd1);
            chk("busy_in_frame", 32'(busy_ok), 32'd1);
            chk("tx_done_end", 32'(mon_done), 32'd1);
            chk("ready_end", 32'(mon_ready), 32'd1);
            chk("busy_end", 32'(mon_busy), 32'd0);
            chk("line_end", 32'(mon_line), 32'd1);
            last_bits = cap;
            frames_seen++;
            in_frame = 0;
            idle_run = 1;
         end
      end
   end

   task automatic wait_ready();
      bit ok;
      ok = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (mon_ready === 1'b1) begin
            ok = 1;
            break;
         end
      end
      chk("ready_timeout", 32'(ok), 32'd1);
   endtask

   task automatic send(input logic [7:0] d);
      exp_q.push_back(make_frame(sel, d));
      @(posedge clk);
      #1;
      valid = 1'b1;
      data  = d;
      wait_ready();
      @(posedge clk);
      #1;
      valid = 1'b0;
      data  = ~d;
   endtask

   task automatic wait_frames(input int target);
      bit ok;
      ok = 0;
      for (int n = 0; n < 500; n++) begin
         @(posedge clk);
         if (frames_seen >= target) begin
            ok = 1;
            break;
         end
      end
      chk("frame_timeout", 32'(ok), 32'd1);
   endtask

   task automatic do_reset(input logic [1:0] s);
      @(posedge clk);
      #1;
      rst   = 1'b1;
      valid = 1'b0;
      sel   = s;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   int f0, d0, b0, s0;
   exp_t e;

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      data  = 8'h00;
      sel   = 2'd0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_line", 32'(mon_line), 32'd1);
      chk("rst_busy", 32'(mon_busy), 32'd0);
      chk("rst_done", 32'(mon_done), 32'd0);
      chk("rst_ready", 32'(mon_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(mon_ready), 32'd1);

      // Defaults, 0xA5
      f0 = frames_seen; d0 = done_cnt; b0 = busy_cnt;
      send(8'hA5);
      wait_frames(f0 + 1);
      chk("a5_sequence", 32'(last_bits), 32'h34A);
      chk("a5_done_count", 32'(done_cnt - d0), 32'd1);
      chk("a5_busy_cycles", 32'(busy_cnt - b0), 32'd40);

      // Back-to-back with valid held
      f0 = frames_seen;
      exp_q.push_back(make_frame(sel, 8'h3C));
      exp_q.push_back(make_frame(sel, 8'hC3));
      @(posedge clk);
      #1;
      valid = 1'b1;
      data  = 8'h3C;
      wait_ready();
      @(posedge clk);
      #1;
      data = 8'hC3;
      wait_ready();
      @(posedge clk);
      #1;
      valid = 1'b0;
      wait_frames(f0 + 2);
      chk("b2b_gap", 32'(last_gap), 32'd1);
      e = make_frame(2'd0, 8'hC3);
      chk("b2b_second", 32'(last_bits), 32'(e.bits));

      // valid_in pulse while busy is ignored
      f0 = frames_seen; s0 = starts_seen; d0 = done_cnt;
      send(8'h00);
      repeat (9) @(posedge clk);
      #1;
      valid = 1'b1;
      data  = 8'hFF;
      @(posedge clk);
      #1;
      valid = 1'b0;
      wait_frames(f0 + 1);
      repeat (30) @(posedge clk);
      chk("ignore_starts", 32'(starts_seen - s0), 32'd1);
      chk("ignore_done", 32'(done_cnt - d0), 32'd1);
      chk("ignore_zero", 32'(last_bits), 32'h200);

      // Reset mid-frame
      f0 = frames_seen; d0 = done_cnt;
      send(8'h00);
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready_pre", 32'(mon_ready), 32'd0);
      @(negedge clk);
      chk("midrst_line", 32'(mon_line), 32'd1);
      chk("midrst_busy", 32'(mon_busy), 32'd0);
      chk("midrst_ready", 32'(mon_ready), 32'd0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      valid = 1'b1;
      data  = 8'h5A;
      exp_q.push_back(make_frame(sel, 8'h5A));
      @(negedge clk);
      chk("postrst_ready", 32'(mon_ready), 32'd1);
      @(posedge clk);
      #1;
      valid = 1'b0;
      #6;
      chk("postrst_start", 32'(mon_line), 32'd0);
      chk("postrst_busy", 32'(mon_busy), 32'd1);
      wait_frames(f0 + 1);
      chk("postrst_done", 32'(done_cnt - d0), 32'd1);
      e = make_frame(2'd0, 8'h5A);
      chk("postrst_bits", 32'(last_bits), 32'(e.bits));

      // Parity enabled
      do_reset(2'd1);
      f0 = frames_seen; b0 = busy_cnt;
      send(8'hA5);
      wait_frames(f0 + 1);
      chk("par_a5_seq", 32'(last_bits), 32'h54A);
      chk("par_a5_bit", 32'(last_bits[9]), 32'd0);
      chk("par_a5_busy", 32'(busy_cnt - b0), 32'd44);
      send(8'h07);
      wait_frames(f0 + 2);
      chk("par_07_bit", 32'(last_bits[9]), 32'd1);

      // One clock per bit, 4 data bits
      do_reset(2'd2);
      f0 = frames_seen; b0 = busy_cnt;
      send(8'h09);
      wait_frames(f0 + 1);
      chk("small_seq", 32'(last_bits), 32'h32);
      chk("small_busy", 32'(busy_cnt - b0), 32'd6);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
